// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU scheduler.
// Opcodes, FSM encoding and the latched grant bundle.
package alu_pkg;

  localparam int W = 64;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         setcc;
    logic         port;
  } grant_t;

endpackage

// File: rtl/ALU_64.sv
// Existing 64-bit Y86-64 ALU: add, sub, and, xor.
// Signed overflow for add/sub, zero flag on result.
module ALU_64 (
  input  logic [1:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] res,
  output logic        overflow,
  output logic        zero
);

  // Result and signed-overflow per opcode
  always_comb begin
    res      = '0;
    overflow = 1'b0;
    case (op)
      2'b00: begin
        res      = a + b;
        overflow = (a[63] == b[63]) && (res[63] != a[63]);
      end
      2'b01: begin
        res      = a - b;
        overflow = (a[63] != b[63]) && (res[63] != a[63]);
      end
      2'b10: res = a & b;
      default: res = a ^ b;
    endcase
  end

  assign zero = (res == '0);

endmodule

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin grant.
// Owns the last-winner pointer; port 0 wins the first tie.
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last;

  // On a tie the port that did not win last time goes
  always_comb begin
    grant = req;
    if (req == 2'b11)
      grant = last ? 2'b01 : 2'b10;
  end

  // Remember the winner of each accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= 1'b1;
    else if (accept)
      last <= grant[1];
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shared ALU scheduler: arbitrate, latch, execute, respond.
// Updates architectural ZF/SF/OF on request.
module alu_share_ctrl
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [1:0]   req_op0,
  input  logic [1:0]   req_op1,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  input  logic [1:0]   req_setcc,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [W-1:0] rsp_res,
  output logic         rsp_ovf,
  output logic         rsp_zero,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic         busy
);

  state_t       state;
  state_t       state_nx;
  logic [1:0]   gnt;
  logic         accept;
  grant_t       grant_d;
  grant_t       grant_q;
  logic [W-1:0] alu_res;
  logic         alu_ovf;
  logic         alu_zero;

  alu_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .accept (accept),
    .grant  (gnt)
  );

  ALU_64 u_alu (
    .op       (grant_q.op),
    .a        (grant_q.a),
    .b        (grant_q.b),
    .res      (alu_res),
    .overflow (alu_ovf),
    .zero     (alu_zero)
  );

  assign req_ready = (state == ST_IDLE) ? gnt : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state != ST_RESP) ? 2'b00 :
                     grant_q.port ? 2'b10 : 2'b01;

  // Select the winning port's payload
  always_comb begin
    grant_d = '0;
    unique case (1'b1)
      gnt[1]: begin
        grant_d.op    = req_op1;
        grant_d.a     = req_a1;
        grant_d.b     = req_b1;
        grant_d.setcc = req_setcc[1];
        grant_d.port  = 1'b1;
      end
      default: begin
        grant_d.op    = req_op0;
        grant_d.a     = req_a0;
        grant_d.b     = req_b0;
        grant_d.setcc = req_setcc[0];
        grant_d.port  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // Next-state: accept, one execute cycle, hold until consumed
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (accept) state_nx = ST_EXEC;
      ST_EXEC: state_nx = ST_RESP;
      ST_RESP: if (rsp_ready[grant_q.port]) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Latch the accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      grant_q <= '0;
    else if (accept)
      grant_q <= grant_d;
  end

  // Capture result, flags and optional condition codes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_res  <= '0;
      rsp_ovf  <= 1'b0;
      rsp_zero <= 1'b0;
      cc_zf    <= 1'b1;
      cc_sf    <= 1'b0;
      cc_of    <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_res  <= alu_res;
      rsp_ovf  <= alu_ovf;
      rsp_zero <= alu_zero;
      if (grant_q.setcc) begin
        cc_zf <= alu_zero;
        cc_sf <= alu_res[W-1];
        cc_of <= alu_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized self-checking bench for alu_share_ctrl.
// Reference model: plain arithmetic plus a round-robin pointer.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_op0 = '0;
  logic [1:0]  req_op1 = '0;
  logic [63:0] req_a0 = '0;
  logic [63:0] req_b0 = '0;
  logic [63:0] req_a1 = '0;
  logic [63:0] req_b1 = '0;
  logic [1:0]  req_setcc = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [63:0] rsp_res;
  logic        rsp_ovf;
  logic        rsp_zero;
  logic        cc_zf;
  logic        cc_sf;
  logic        cc_of;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic       m_last = 1'b1;
  logic [2:0] m_cc = 3'b100;

  alu_share_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_setcc (req_setcc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_ovf   (rsp_ovf),
    .rsp_zero  (rsp_zero),
    .cc_zf     (cc_zf),
    .cc_sf     (cc_sf),
    .cc_of     (cc_of),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Result and overflow from exact signed arithmetic
  function automatic logic [64:0] ref_alu(input logic [1:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
    logic signed [65:0] sa;
    logic signed [65:0] sb;
    logic signed [65:0] w;
    logic [63:0] r;
    logic ov;
    sa = {{2{a[63]}}, a};
    sb = {{2{b[63]}}, b};
    ov = 1'b0;
    case (op)
      2'b00: w = sa + sb;
      2'b01: w = sa - sb;
      2'b10: w = {2'b00, a & b};
      default: w = {2'b00, a ^ b};
    endcase
    r = w[63:0];
    if (op[1] == 1'b0)
      ov = (w != {{2{r[63]}}, r});
    return {ov, r};
  endfunction

  task automatic do_op(input logic [1:0] v,
                       input logic [1:0] o0, input logic [63:0] a0,
                       input logic [63:0] b0, input logic s0,
                       input logic [1:0] o1, input logic [63:0] a1,
                       input logic [63:0] b1, input logic s1,
                       input int hold);
    logic g;
    logic [1:0] oh;
    logic [64:0] e;
    logic [63:0] er;
    logic sc;
    req_valid = v;
    req_op0 = o0; req_a0 = a0; req_b0 = b0;
    req_op1 = o1; req_a1 = a1; req_b1 = b1;
    req_setcc = {s1, s0};
    g = (v == 2'b11) ? ~m_last : v[1];
    oh = g ? 2'b10 : 2'b01;
    e = g ? ref_alu(o1, a1, b1) : ref_alu(o0, a0, b0);
    er = e[63:0];
    sc = g ? s1 : s0;
    @(negedge clk);
    check("idle_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    check("grant", {62'd0, req_ready}, {62'd0, oh});
    check("idle_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    m_last = g;
    req_valid = 2'b11;
    @(negedge clk);
    check("exec_ready", {62'd0, req_ready}, 64'd0);
    check("exec_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    check("exec_busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    if (sc) m_cc = {er == 64'd0, er[63], e[64]};
    @(negedge clk);
    check("rsp_valid", {62'd0, rsp_valid}, {62'd0, oh});
    check("rsp_res", rsp_res, er);
    check("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, e[64]});
    check("rsp_zero", {63'd0, rsp_zero}, {63'd0, er == 64'd0});
    check("cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, m_cc});
    for (int i = 0; i < hold; i++) begin
      rsp_ready = ~oh;
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_valid", {62'd0, rsp_valid}, {62'd0, oh});
      check("hold_res", rsp_res, er);
      check("hold_ready", {62'd0, req_ready}, 64'd0);
    end
    rsp_ready = oh;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    req_valid = 2'b00;
  endtask

  task automatic rand_op(input logic [1:0] v, input int hold);
    logic [63:0] a0, b0, a1, b1;
    a0 = {$urandom, $urandom};
    b0 = ($urandom_range(0, 3) == 0) ? a0 : {$urandom, $urandom};
    a1 = {$urandom, $urandom};
    b1 = ($urandom_range(0, 3) == 0) ? a1 : {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) a0[62:0] = '1;
    do_op(v, 2'($urandom), a0, b0, 1'($urandom),
          2'($urandom), a1, b1, 1'($urandom), hold);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ready", {62'd0, req_ready}, 64'd0);
    check("rst_valid", {62'd0, rsp_valid}, 64'd0);
    check("rst_res", rsp_res, 64'd0);
    check("rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(2'b01, 2'b00, 64'd11, 64'd42, 1'b1,
          2'b00, 64'd0, 64'd0, 1'b0, 0);
    check("add_res", rsp_res, 64'd53);
    do_op(2'b10, 2'b00, 64'd0, 64'd0, 1'b0,
          2'b01, 64'd11, 64'd42, 1'b1, 0);
    check("sub_res", rsp_res, -64'sd31);
    check("sub_sf", {63'd0, cc_sf}, 64'd1);
    do_op(2'b01, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1,
          2'b00, 64'd0, 64'd0, 1'b0, 0);
    check("ovf_flag", {63'd0, rsp_ovf}, 64'd1);
    check("ovf_cc", {63'd0, cc_of}, 64'd1);
    do_op(2'b01, 2'b11, 64'h1234, 64'h1234, 1'b0,
          2'b00, 64'd0, 64'd0, 1'b0, 0);
    check("xor_zero", {63'd0, rsp_zero}, 64'd1);
    check("xor_cc_kept", {61'd0, cc_zf, cc_sf, cc_of}, 64'd3);

    for (int i = 0; i < 4; i++)
      rand_op(2'b11, 0);

    do_op(2'b01, 2'b00, 64'd5, 64'd6, 1'b1,
          2'b00, 64'd0, 64'd0, 1'b0, 5);

    // Reset while the op is in EXEC
    req_valid = 2'b10;
    req_op1 = 2'b01; req_a1 = 64'd1; req_b1 = 64'd2;
    req_setcc = 2'b10;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_last = 1'b1;
    m_cc = 3'b100;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_valid", {62'd0, rsp_valid}, 64'd0);
    check("mid_rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_valid", {62'd0, rsp_valid}, 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++)
      rand_op(2'($urandom_range(1, 3)), $urandom_range(0, 3));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester scheduler and sequencer for the shared 64-bit ALU in the Y86-64 pipeline. It arbitrates round-robin between the execute stage (port 0) and the auxiliary address/compare path (port 1), latches the winning operands, drives one `ALU_64` instance, and registers the result. It also returns the result to the winning requester with a valid/ready handshake and optionally updates the architectural condition codes (ZF, SF, OF).

## Interface
- `W`, 64, operand/result width; fixed to match `ALU_64`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid[1:0]`  in  2  request valid per port.
- `req_ready[1:0]`  out  2  request accepted this cycle.
- `req_op0`, `req_op1`  in  2 each  opcode: 00 add, 01 sub (a−b), 10 and, 11 xor.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  64 each  signed operands.
- `req_setcc[1:0]`  in  2  update CC when this op completes.
- `rsp_valid[1:0]`  out  2  result valid, one-hot, for the granted port.
- `rsp_ready[1:0]`  in  2  requester consumes result.
- `rsp_res`  out  64  registered ALU result.
- `rsp_ovf`, `rsp_zero`  out  1 each  registered ALU flags for this op.
- `cc_zf`, `cc_sf`, `cc_of`  out  1 each  architectural condition codes.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- **IDLE:** combinational grant among asserted `req_valid`. `req_ready[g]=1` only for the granted port. On the edge with valid&ready, latch op, a, b, setcc and port id into `grant_q`, then go to EXEC.
- **Arbitration:** round-robin with a 1-bit `last` pointer. When both ports are valid, the port ≠ `last` wins. `last` updates on each accept. Reset sets `last=1`, so port 0 wins the first tie.
- **EXEC:** the ALU sees the latched operands. On the clock edge, capture `res`, `overflow` and `zero` into the rsp registers. If setcc is latched, also update `cc_zf=zero`, `cc_sf=res[63]` and `cc_of=overflow`. Then go to RESP.
- **RESP:** `rsp_valid[grant_q]=1` and all rsp outputs stay stable. When `rsp_ready[grant_q]=1`, go to IDLE. No new request is accepted in EXEC or RESP, so `req_ready=0` there.
- **Arithmetic:** two's-complement, result wraps modulo 2^64. Overflow follows signed rules: for add, operands have the same sign and the result sign differs; for sub, operands have different signs and the result sign differs from a. For and/xor, overflow is 0.
- **Requester rules:** `req_*` payload must remain stable while valid and not ready. Deasserting valid before acceptance withdraws the request.
- **Ignored signals:** `rsp_ready` on the non-granted port, and while not in RESP, are ignored.

## Timing
- **Reset values:** state IDLE, `req_ready=0` until a valid is seen (it is combinational), `rsp_valid=0`, `rsp_res=0`, `rsp_ovf=0`, `rsp_zero=0`, `cc_zf=1`, `cc_sf=0`, `cc_of=0`, `busy=0`, `last=1`.
- **Latency:** accept at edge E0. Result registered at E1. `rsp_valid` is high from E1 to the edge where it is consumed. Minimum 3 cycles per op: IDLE, EXEC, RESP with `rsp_ready` held high.
- **Ready timing:** `req_ready` is combinational from `req_valid`, `last` and state. `rsp_*` outputs are fully registered.
- **Reset mid-operation:** returns to IDLE immediately. The in-flight op is discarded, CC is restored to its reset values, and no `rsp_valid` pulse is produced.
- **Single requester:** a lone requester is granted regardless of `last`.

## Structure
- **Shared package `alu_pkg`:** opcode localparams (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_XOR`), the FSM state encoding (2-bit), and `W`.
- **Sub-module `alu_rr_arb2`:** combinational 2-way round-robin grant that owns the `last` register. Inputs: req[1:0], accept. Output: grant one-hot.
- **Reused block:** the existing `ALU_64` is instantiated unchanged.

## Test plan
- **Single add:** reset, port0 requests add a=11, b=42, setcc=1. Required: `rsp_valid[0]` one cycle after accept, res=53, zf=0, sf=0, of=0.
- **Sub with negative result:** port1 requests sub a=11, b=42. Required: res=−31, `cc_sf=1`, ZF=0.
- **Overflow:** add a=0x7FFF_FFFF_FFFF_FFFF, b=1. Required: res=0x8000_0000_0000_0000, ovf=1, cc_of=1.
- **Zero result without CC update:** xor a=b=0x1234, setcc=0. Required: rsp_zero=1, CC unchanged from the prior op.
- **Contention fairness:** both ports valid continuously with `rsp_ready` held high. Required: grants alternate 0,1,0,1 starting with port 0. Each grant waits for the previous RESP handshake, and `req_ready` stays low in EXEC and RESP.
- **Reset and backpressure:** assert `rst_n=0` in EXEC, then release. Required: no `rsp_valid`, CC back to zf=1, sf=0, of=0. Separately, hold `rsp_ready=0` for 5 cycles. Required: `rsp_valid` and `rsp_res` stay stable and no new accept occurs.
